// File: rtl/mux_rr_arbiter.sv
// Round-robin owner arbiter for a 4:1 data mux; grant held for a requester's whole burst.
// Optional hold timeout under ARB_TIMEOUT_EN (MAX_HOLD cycles per grant); default build holds indefinitely.
module mux_rr_arbiter #(
  parameter int DW       = 8,
  parameter int MAX_HOLD = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      req,
  input  logic [4*DW-1:0] din,
  output logic [3:0]      gnt,
  output logic [1:0]      sel,
  output logic [DW-1:0]   dout,
  output logic            busy
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t     state, state_nxt;
  logic [3:0] gnt_nxt;
  logic [1:0] sel_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [1:0] search_start;
  logic       rearb;
  logic [2:0] pick;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt, hold_nxt;
`endif

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("mux_rr_arbiter: MAX_HOLD must be within 1..255");
  end

  // Returns {found, index}; lowest rotation offset from start wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    sel_nxt      = sel;
    ptr_nxt      = ptr;
    search_start = ptr;
    rearb        = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_nxt     = hold_cnt;
`endif
    case (state)
      IDLE: rearb = 1'b1;
      OWN: begin
        rearb = ~req[sel];
`ifdef ARB_TIMEOUT_EN
        // On timeout the current owner is searched last, so it only wins if alone.
        if (hold_cnt == 8'(MAX_HOLD - 1)) begin
          rearb        = 1'b1;
          search_start = sel + 2'd1;
        end else if (!rearb) begin
          hold_nxt = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase

    pick = rr_pick(req, search_start);
    if (rearb) begin
      if (pick[2]) begin
        state_nxt = OWN;
        gnt_nxt   = 4'b0001 << pick[1:0];
        sel_nxt   = pick[1:0];
        ptr_nxt   = pick[1:0] + 2'd1;
`ifdef ARB_TIMEOUT_EN
        hold_nxt  = 8'd0;
`endif
      end else begin
        state_nxt = IDLE;
        gnt_nxt   = 4'b0000;
        sel_nxt   = 2'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      sel      <= 2'd0;
      ptr      <= 2'd0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt <= 8'd0;
`endif
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
      ptr      <= ptr_nxt;
`ifdef ARB_TIMEOUT_EN
      hold_cnt <= hold_nxt;
`endif
    end
  end

  assign busy = (state == OWN);

  // Unregistered data path: owner's slice passes straight through.
  always_comb begin
    dout = '0;
    if (busy) dout = din[int'(sel)*DW +: DW];
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: behavioural model pushes expectations, DUT outputs popped after each edge.
module tb_mux_rr_arbiter;
  localparam int DW       = 8;
  localparam int MAX_HOLD = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req;
  logic [4*DW-1:0] din;
  logic [3:0]      gnt;
  logic [1:0]      sel;
  logic [DW-1:0]   dout;
  logic            busy;

  mux_rr_arbiter #(.DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din),
    .gnt(gnt), .sel(sel), .dout(dout), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic          busy;
    logic [DW-1:0] dout;
  } exp_t;

  exp_t sb_q[$];
  int   err_cnt = 0;
  int   chk_cnt = 0;

  bit m_busy;
  int m_own, m_ptr, m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rr_search(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++)
      if (r[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  task automatic model_grant(input logic [3:0] r, input int start);
    int w;
    w = rr_search(r, start);
    if (w < 0) m_busy = 1'b0;
    else begin
      m_busy = 1'b1;
      m_own  = w;
      m_ptr  = (w + 1) % 4;
      m_cnt  = 0;
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_own  = 0;
    m_ptr  = 0;
    m_cnt  = 0;
  endtask

  task automatic step(input logic [3:0] r, input logic [4*DW-1:0] d);
    exp_t e, o;
    @(negedge clk);
    req = r;
    din = d;
    if (!m_busy) model_grant(r, m_ptr);
`ifdef ARB_TIMEOUT_EN
    else if (m_cnt == MAX_HOLD - 1) model_grant(r, (m_own + 1) % 4);
`endif
    else if (r[m_own]) begin
      if (m_cnt < 255) m_cnt++;
    end
    else model_grant(r, m_ptr);
    e.gnt  = m_busy ? 4'(1 << m_own) : 4'd0;
    e.sel  = m_busy ? 2'(m_own) : 2'd0;
    e.busy = m_busy;
    e.dout = m_busy ? d[m_own*DW +: DW] : '0;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    o = sb_q.pop_front();
    check("sb_gnt",  32'(gnt),  32'(o.gnt));
    check("sb_sel",  32'(sel),  32'(o.sel));
    check("sb_busy", 32'(busy), 32'(o.busy));
    check("sb_dout", 32'(dout), 32'(o.dout));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4*DW-1:0] d;
    rst = 1'b1;
    req = 4'd0;
    din = '0;
    model_reset();
    #12;
    check("reset_gnt",  32'(gnt),  0);
    check("reset_sel",  32'(sel),  0);
    check("reset_busy", 32'(busy), 0);
    check("reset_dout", 32'(dout), 0);
    @(negedge clk);
    rst = 1'b0;

    // single requester
    d = 32'h00A5_0000;
    step(4'b0100, d);
    check("single_gnt",  32'(gnt),  'h4);
    check("single_sel",  32'(sel),  2);
    check("single_busy", 32'(busy), 1);
    check("single_dout", 32'(dout), 'hA5);
    step(4'b0000, d);
    check("single_idle_dout", 32'(dout), 0);
    check("single_idle_busy", 32'(busy), 0);

    // asynchronous reset mid-burst
    d = 32'h4433_2211;
    step(4'b1111, d);
    step(4'b1111, d);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_gnt",  32'(gnt),  0);
    check("rst_async_sel",  32'(sel),  0);
    check("rst_async_busy", 32'(busy), 0);
    check("rst_async_dout", 32'(dout), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // round-robin order with direct handoffs
    step(4'hF, d);
    for (int g = 0; g < 5; g++) begin
      check($sformatf("rr_order%0d", g), 32'(gnt), 1 << (g % 4));
      check($sformatf("rr_busy%0d", g), 32'(busy), 1);
      if (g < 4) begin
        step(4'hF, d);
        step(4'hF, d);
        step(4'hF & ~gnt, d);
      end
    end
    step(4'b0000, d);

    // handoff: late request waits for owner release
    step(4'b0010, d);
    check("hand_own1", 32'(gnt), 'h2);
    step(4'b1010, d);
    check("hand_hold_a", 32'(gnt), 'h2);
    step(4'b1010, d);
    check("hand_hold_b", 32'(gnt), 'h2);
    step(4'b1000, d);
    check("hand_to3",   32'(gnt),  'h8);
    check("hand_busy",  32'(busy), 1);
    step(4'b0000, d);

    // pointer wrap 3 -> 0
    step(4'b0100, d);
    step(4'b0000, d);
    step(4'b1001, d);
    check("wrap_gnt3", 32'(gnt), 'h8);
    check("wrap_sel3", 32'(sel), 3);
    step(4'b0001, d);
    check("wrap_gnt0", 32'(gnt), 'h1);
    step(4'b0000, d);

    // two held requests
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      step(4'b0011, d);
`ifndef ARB_TIMEOUT_EN
      check("no_timeout_hold", 32'(gnt), 'h1);
`endif
    end
    step(4'b0000, d);

    // random traffic
    for (int i = 0; i < 300; i++)
      step(4'($urandom_range(0, 15)), $urandom);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
